// File: rtl/root_stage_controller_if.sv
// Host and child-controller signals of the root stage sequencer; master = sequencer side.
// watchdog_error exists only when WATCHDOG_EN is defined.
interface root_stage_controller_if #(
  parameter int CHILD_COUNT             = 4,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int STAGE_WIDTH             = 3
);
  logic                               start;
  logic [CHILD_COUNT-1:0]             busy_child;
  logic [CHILD_COUNT-1:0]             odd_clusters_child;
  logic [STAGE_WIDTH-1:0]             global_stage;
  logic                               decoding_start;
  logic                               next_iteration;
  logic                               peel_release;
  logic                               result_valid;
  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter;
  logic [31:0]                        cycle_counter;
  logic                               overflow;
`ifdef WATCHDOG_EN
  logic                               watchdog_error;
`endif

  modport master (
    input  start, busy_child, odd_clusters_child,
    output global_stage, decoding_start, next_iteration, peel_release,
           result_valid, iteration_counter, cycle_counter, overflow
`ifdef WATCHDOG_EN
    , output watchdog_error
`endif
  );

  modport slave (
    output start, busy_child, odd_clusters_child,
    input  global_stage, decoding_start, next_iteration, peel_release,
           result_valid, iteration_counter, cycle_counter, overflow
`ifdef WATCHDOG_EN
    , input watchdog_error
`endif
  );
endinterface

// File: rtl/root_stage_controller.sv
// Root stage sequencer: LOAD -> (GROW -> MERGE)* -> PEEL -> RESULT; registered outputs, child flags seen one cycle late.
// No backpressure: children are steered by level/toggle/pulse. `define WATCHDOG_EN adds a MERGE timeout.
module root_stage_controller #(
  parameter int CHILD_COUNT             = 4,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAX_ITERATIONS          = 200,
  parameter int LOAD_CYCLES             = 2,
  parameter int MIN_SETTLE              = 4,
  parameter int QUIET_CYCLES            = 2,
  parameter int PEEL_CYCLES             = 8,
  parameter int WATCHDOG_CYCLES         = 1024,
  parameter int STAGE_WIDTH             = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  root_stage_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GROW   = 3'd2,
    ST_MERGE  = 3'd3,
    ST_PEEL   = 3'd4,
    ST_RESULT = 3'd5
  } stage_t;

  // One shared width for all small phase counters, wide enough for the largest limit.
  localparam int M1 = (LOAD_CYCLES > MIN_SETTLE) ? LOAD_CYCLES : MIN_SETTLE;
  localparam int M2 = (QUIET_CYCLES > PEEL_CYCLES) ? QUIET_CYCLES : PEEL_CYCLES;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int CNT_MAX = (M3 > WATCHDOG_CYCLES) ? M3 : WATCHDOG_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [31:0] MAX_IT = 32'(MAX_ITERATIONS);

  stage_t stage_q, stage_nxt;
  logic [CHILD_COUNT-1:0] busy_in, odd_in;
  logic busy_r, odd_r;
  logic [CW-1:0] load_q, delay_q, quiet_q, peel_q;
  logic [ITERATION_COUNTER_WIDTH-1:0] iter_q;
  logic [31:0] cyc_q;
  logic ds_q, ni_q, pr_q, rv_q, ovf_q;
  logic settled, quiet_hit, below_cap, decide_grow, set_ovf;
`ifdef WATCHDOG_EN
  logic [CW-1:0] wd_q;
  logic wd_err_q, wd_fire;
`endif

  assign busy_in   = bus.busy_child;
  assign odd_in    = bus.odd_clusters_child;
  assign settled   = (delay_q == CW'(MIN_SETTLE));
  // Decision fires on the cycle that completes QUIET_CYCLES consecutive idle observations.
  assign quiet_hit = settled && !busy_r && (quiet_q == CW'(QUIET_CYCLES - 1));
  assign below_cap = (32'(iter_q) < MAX_IT);

  always_comb begin
    stage_nxt   = stage_q;
    decide_grow = 1'b0;
    set_ovf     = 1'b0;
`ifdef WATCHDOG_EN
    wd_fire     = 1'b0;
`endif
    case (stage_q)
      ST_IDLE:  if (bus.start) stage_nxt = ST_LOAD;
      ST_LOAD:  if (load_q == CW'(LOAD_CYCLES - 1)) stage_nxt = ST_GROW;
      ST_GROW:  stage_nxt = ST_MERGE;
      ST_MERGE: begin
        if (quiet_hit) begin
          if (odd_r && below_cap) begin
            decide_grow = 1'b1;
            stage_nxt   = ST_GROW;
          end else begin
            set_ovf   = odd_r;
            stage_nxt = ST_PEEL;
          end
        end
`ifdef WATCHDOG_EN
        else if (wd_q == CW'(WATCHDOG_CYCLES - 1)) begin
          wd_fire   = 1'b1;
          stage_nxt = ST_RESULT;
        end
`endif
      end
      ST_PEEL:   if (peel_q == CW'(PEEL_CYCLES - 1)) stage_nxt = ST_RESULT;
      ST_RESULT: stage_nxt = ST_IDLE;
      default:   stage_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q  <= ST_IDLE;
      busy_r   <= 1'b0;
      odd_r    <= 1'b0;
      load_q   <= '0;
      delay_q  <= '0;
      quiet_q  <= '0;
      peel_q   <= '0;
      iter_q   <= '0;
      cyc_q    <= '0;
      ds_q     <= 1'b0;
      ni_q     <= 1'b0;
      pr_q     <= 1'b0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q     <= '0;
      wd_err_q <= 1'b0;
`endif
    end else begin
      stage_q <= stage_nxt;
      busy_r  <= |busy_in;
      odd_r   <= |odd_in;
      pr_q    <= 1'b0;
      rv_q    <= 1'b0;
      if (stage_nxt == ST_GROW && iter_q != '1) iter_q <= iter_q + 1'b1;
      if (stage_q != ST_IDLE && stage_q != ST_RESULT && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      case (stage_q)
        ST_IDLE: if (bus.start) begin
          ds_q     <= 1'b1;
          iter_q   <= '0;
          cyc_q    <= 32'd1;
          ovf_q    <= 1'b0;
          load_q   <= '0;
          delay_q  <= '0;
          quiet_q  <= '0;
`ifdef WATCHDOG_EN
          wd_err_q <= 1'b0;
`endif
        end
        ST_LOAD: load_q <= load_q + 1'b1;
        ST_GROW: begin
          delay_q <= '0;
          quiet_q <= '0;
`ifdef WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        ST_MERGE: begin
          if (!settled)    delay_q <= delay_q + 1'b1;
          else if (busy_r) quiet_q <= '0;
          else             quiet_q <= quiet_q + 1'b1;
          if (decide_grow) ni_q <= ~ni_q;
          if (stage_nxt == ST_PEEL) begin
            ds_q   <= 1'b0;
            peel_q <= '0;
            if (set_ovf) ovf_q <= 1'b1;
          end
`ifdef WATCHDOG_EN
          wd_q <= wd_q + 1'b1;
          if (wd_fire) begin
            ds_q     <= 1'b0;
            wd_err_q <= 1'b1;
          end
`endif
        end
        ST_PEEL: begin
          peel_q <= peel_q + 1'b1;
          if (stage_nxt == ST_RESULT) pr_q <= 1'b1;
        end
        ST_RESULT: rv_q <= 1'b1;
        default:   ds_q <= 1'b0;
      endcase
    end
  end

  assign bus.global_stage      = STAGE_WIDTH'(stage_q);
  assign bus.decoding_start    = ds_q;
  assign bus.next_iteration    = ni_q;
  assign bus.peel_release      = pr_q;
  assign bus.result_valid      = rv_q;
  assign bus.iteration_counter = iter_q;
  assign bus.cycle_counter     = cyc_q;
  assign bus.overflow          = ovf_q;
`ifdef WATCHDOG_EN
  assign bus.watchdog_error    = wd_err_q;
`endif

endmodule
